mlp_layer_sequencer: RTL and testbench

//   Runtime-configurable sequencer for one fully-connected MLP layer. Drives neuron/weight RAM addresses and
//   MAC strobes: per output neuron, clear accumulator, stream n_in products, drain MAC pipeline, write result.

---
 rtl/mlp_pkg.sv | 23 ++
 rtl/mlp_layer_sequencer_if.sv | 45 ++++
 rtl/mlp_addr_gen.sv | 121 ++++++++++++
 rtl/mlp_layer_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_mlp_layer_sequencer.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mlp_pkg.sv
// Shared definitions for the MLP layer sequencer: sequencer states and default widths.
package mlp_pkg;

    localparam int unsigned NEURON_AW_DEF = 12;
    localparam int unsigned WEIGHT_AW_DEF = 16;
    localparam int unsigned MAC_LAT_DEF   = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_BIAS  = 3'd2,
        ST_ACC   = 3'd3,
        ST_DRAIN = 3'd4,
        ST_WRITE = 3'd5,
        ST_DONE  = 3'd6
    } seq_state_e;

    // Only the per-neuron working states can be frozen by a memory stall.
    function automatic logic is_stallable(input seq_state_e s);
        return (s != ST_IDLE) && (s != ST_DONE);
    endfunction

endpackage

// File: rtl/mlp_layer_sequencer_if.sv
// Config / strobe / address bundle between layer control, sequencer and the MAC datapath.
// Bias ports exist only when MLP_BIAS_EN is defined.
interface mlp_layer_sequencer_if #(
    parameter int unsigned NEURON_AW = 12,
    parameter int unsigned WEIGHT_AW = 16
) ();
    logic                 start;
    logic [NEURON_AW-1:0] n_in;
    logic [NEURON_AW-1:0] n_out;
    logic [NEURON_AW-1:0] in_base;
    logic [NEURON_AW-1:0] out_base;
    logic [WEIGHT_AW-1:0] w_base;
    logic                 stall;
    logic [NEURON_AW-1:0] in_addr;
    logic [WEIGHT_AW-1:0] w_addr;
    logic [NEURON_AW-1:0] out_addr;
    logic                 mac_clr;
    logic                 mac_en;
    logic                 write_neuron;
    logic                 busy;
    logic                 done;
`ifdef MLP_BIAS_EN
    logic [NEURON_AW-1:0] b_base;
    logic [NEURON_AW-1:0] bias_addr;
    logic                 bias_load;
`endif

    modport master (
        output start, n_in, n_out, in_base, out_base, w_base, stall,
`ifdef MLP_BIAS_EN
        output b_base,
        input  bias_addr, bias_load,
`endif
        input  in_addr, w_addr, out_addr, mac_clr, mac_en, write_neuron, busy, done
    );

    modport slave (
        input  start, n_in, n_out, in_base, out_base, w_base, stall,
`ifdef MLP_BIAS_EN
        input  b_base,
        output bias_addr, bias_load,
`endif
        output in_addr, w_addr, out_addr, mac_clr, mac_en, write_neuron, busy, done
    );
endinterface

// File: rtl/mlp_addr_gen.sv
// Address generator: latched layer config, input/neuron counters, running weight pointer
// and base-plus-offset address adders (optional bias address under MLP_BIAS_EN).
module mlp_addr_gen
    import mlp_pkg::*;
#(
    parameter int unsigned NEURON_AW = NEURON_AW_DEF,
    parameter int unsigned WEIGHT_AW = WEIGHT_AW_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic [NEURON_AW-1:0] n_in_i,
    input  logic [NEURON_AW-1:0] n_out_i,
    input  logic [NEURON_AW-1:0] in_base_i,
    input  logic [NEURON_AW-1:0] out_base_i,
    input  logic [WEIGHT_AW-1:0] w_base_i,
`ifdef MLP_BIAS_EN
    input  logic [NEURON_AW-1:0] b_base_i,
    output logic [NEURON_AW-1:0] bias_addr_s,
`endif
    input  logic                 clr_i,
    input  logic                 beat_i,
    input  logic                 next_j_i,
    output logic [NEURON_AW-1:0] in_addr_s,
    output logic [WEIGHT_AW-1:0] w_addr_s,
    output logic [NEURON_AW-1:0] out_addr_s,
    output logic                 acc_last_s,
    output logic                 neuron_last_s
);
    localparam logic [NEURON_AW-1:0] N_ONE = {{(NEURON_AW-1){1'b0}}, 1'b1};
    localparam logic [WEIGHT_AW-1:0] W_ONE = {{(WEIGHT_AW-1){1'b0}}, 1'b1};

    logic [NEURON_AW-1:0] n_in_q, n_in_d, n_out_q, n_out_d;
    logic [NEURON_AW-1:0] in_base_q, in_base_d, out_base_q, out_base_d;
    logic [NEURON_AW-1:0] i_q, i_d, j_q, j_d;
    logic [WEIGHT_AW-1:0] wptr_q, wptr_d;
`ifdef MLP_BIAS_EN
    logic [NEURON_AW-1:0] b_base_q, b_base_d;
`endif

    // i_q is the index of the next accumulate beat; wptr_q keeps running across neurons.
    always_comb begin
        n_in_d     = n_in_q;
        n_out_d    = n_out_q;
        in_base_d  = in_base_q;
        out_base_d = out_base_q;
        i_d        = i_q;
        j_d        = j_q;
        wptr_d     = wptr_q;
`ifdef MLP_BIAS_EN
        b_base_d   = b_base_q;
`endif
        if (load_i) begin
            n_in_d     = n_in_i;
            n_out_d    = n_out_i;
            in_base_d  = in_base_i;
            out_base_d = out_base_i;
            i_d        = {NEURON_AW{1'b0}};
            j_d        = {NEURON_AW{1'b0}};
            wptr_d     = w_base_i;
`ifdef MLP_BIAS_EN
            b_base_d   = b_base_i;
`endif
        end else begin
            if (clr_i) begin
                i_d = {NEURON_AW{1'b0}};
            end else if (beat_i) begin
                i_d = i_q + N_ONE;
            end else begin
                i_d = i_q;
            end
            if (beat_i) begin
                wptr_d = wptr_q + W_ONE;
            end else begin
                wptr_d = wptr_q;
            end
            if (next_j_i) begin
                j_d = j_q + N_ONE;
            end else begin
                j_d = j_q;
            end
        end
    end

    // Counter and config registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            n_in_q     <= {NEURON_AW{1'b0}};
            n_out_q    <= {NEURON_AW{1'b0}};
            in_base_q  <= {NEURON_AW{1'b0}};
            out_base_q <= {NEURON_AW{1'b0}};
            i_q        <= {NEURON_AW{1'b0}};
            j_q        <= {NEURON_AW{1'b0}};
            wptr_q     <= {WEIGHT_AW{1'b0}};
`ifdef MLP_BIAS_EN
            b_base_q   <= {NEURON_AW{1'b0}};
`endif
        end else begin
            n_in_q     <= n_in_d;
            n_out_q    <= n_out_d;
            in_base_q  <= in_base_d;
            out_base_q <= out_base_d;
            i_q        <= i_d;
            j_q        <= j_d;
            wptr_q     <= wptr_d;
`ifdef MLP_BIAS_EN
            b_base_q   <= b_base_d;
`endif
        end
    end

    assign in_addr_s     = in_base_q + i_q;
    assign w_addr_s      = wptr_q;
    assign out_addr_s    = out_base_q + j_q;
    assign acc_last_s    = (i_q == n_in_q);
    assign neuron_last_s = ((j_q + N_ONE) == n_out_q);
`ifdef MLP_BIAS_EN
    assign bias_addr_s   = b_base_q + j_q;
`endif

endmodule

// File: rtl/mlp_layer_sequencer.sv
// Fully-connected layer sequencer: per output neuron clear, accumulate n_in beats, drain, write.
// Defining MLP_BIAS_EN adds a one-cycle bias-load step between clear and accumulate.
module mlp_layer_sequencer
    import mlp_pkg::*;
#(
    parameter int unsigned NEURON_AW = NEURON_AW_DEF,
    parameter int unsigned WEIGHT_AW = WEIGHT_AW_DEF,
    parameter int unsigned MAC_LAT   = MAC_LAT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    mlp_layer_sequencer_if.slave bus
);
    localparam logic [15:0] DRAIN_CYC = 16'(MAC_LAT);
`ifdef MLP_BIAS_EN
    localparam seq_state_e AFTER_CLR = ST_BIAS;
`else
    localparam seq_state_e AFTER_CLR = ST_ACC;
`endif

    seq_state_e           state_q, state_d;
    logic [15:0]          drain_q, drain_d;
    logic                 mac_clr_q, mac_clr_d, mac_en_q, mac_en_d;
    logic                 write_q, write_d, busy_q, busy_d, done_q, done_d;
    logic [NEURON_AW-1:0] in_addr_q, in_addr_d, out_addr_q, out_addr_d;
    logic [WEIGHT_AW-1:0] w_addr_q, w_addr_d;
    logic                 hold_s, load_s, clr_s, beat_s, wr_s, next_j_s;
    logic [NEURON_AW-1:0] in_addr_s, out_addr_s;
    logic [WEIGHT_AW-1:0] w_addr_s;
    logic                 acc_last_s, neuron_last_s;
`ifdef MLP_BIAS_EN
    logic                 bias_load_q, bias_load_d, bias_s;
    logic [NEURON_AW-1:0] bias_addr_q, bias_addr_d, bias_addr_s;
`endif

    mlp_addr_gen #(
        .NEURON_AW (NEURON_AW),
        .WEIGHT_AW (WEIGHT_AW)
    ) u_addr_gen (
        .clk           (clk),
        .rst           (rst),
        .load_i        (load_s),
        .n_in_i        (bus.n_in),
        .n_out_i       (bus.n_out),
        .in_base_i     (bus.in_base),
        .out_base_i    (bus.out_base),
        .w_base_i      (bus.w_base),
`ifdef MLP_BIAS_EN
        .b_base_i      (bus.b_base),
        .bias_addr_s   (bias_addr_s),
`endif
        .clr_i         (clr_s),
        .beat_i        (beat_s),
        .next_j_i      (next_j_s),
        .in_addr_s     (in_addr_s),
        .w_addr_s      (w_addr_s),
        .out_addr_s    (out_addr_s),
        .acc_last_s    (acc_last_s),
        .neuron_last_s (neuron_last_s)
    );

    // Next state, and the strobes/addresses for the step issued in the next cycle.
    always_comb begin
        state_d  = state_q;
        drain_d  = drain_q;
        load_s   = 1'b0;
        next_j_s = 1'b0;
        hold_s   = bus.stall && is_stallable(state_q);
        if (hold_s) begin
            state_d = state_q;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        load_s = 1'b1;
                        if ((bus.n_in == {NEURON_AW{1'b0}}) || (bus.n_out == {NEURON_AW{1'b0}})) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_CLR;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_CLR:  state_d = AFTER_CLR;
                ST_BIAS: state_d = ST_ACC;
                ST_ACC: begin
                    if (!acc_last_s) begin
                        state_d = ST_ACC;
                    end else if (DRAIN_CYC == 16'd0) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_DRAIN;
                        drain_d = 16'd1;
                    end
                end
                ST_DRAIN: begin
                    if (drain_q >= DRAIN_CYC) begin
                        state_d = ST_WRITE;
                    end else begin
                        drain_d = drain_q + 16'd1;
                    end
                end
                ST_WRITE: begin
                    if (neuron_last_s) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d  = ST_CLR;
                        next_j_s = 1'b1;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end

        clr_s      = !hold_s && (state_d == ST_CLR);
        beat_s     = !hold_s && (state_d == ST_ACC);
        wr_s       = !hold_s && (state_d == ST_WRITE);
        mac_clr_d  = clr_s;
        mac_en_d   = beat_s;
        write_d    = wr_s;
        done_d     = (state_d == ST_DONE);
        busy_d     = (state_d != ST_IDLE);
        in_addr_d  = beat_s ? in_addr_s  : in_addr_q;
        w_addr_d   = beat_s ? w_addr_s   : w_addr_q;
        out_addr_d = wr_s   ? out_addr_s : out_addr_q;
`ifdef MLP_BIAS_EN
        bias_s      = !hold_s && (state_d == ST_BIAS);
        bias_load_d = bias_s;
        bias_addr_d = bias_s ? bias_addr_s : bias_addr_q;
`endif
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            drain_q     <= 16'd0;
            mac_clr_q   <= 1'b0;
            mac_en_q    <= 1'b0;
            write_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            in_addr_q   <= {NEURON_AW{1'b0}};
            w_addr_q    <= {WEIGHT_AW{1'b0}};
            out_addr_q  <= {NEURON_AW{1'b0}};
`ifdef MLP_BIAS_EN
            bias_load_q <= 1'b0;
            bias_addr_q <= {NEURON_AW{1'b0}};
`endif
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            mac_clr_q   <= mac_clr_d;
            mac_en_q    <= mac_en_d;
            write_q     <= write_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            in_addr_q   <= in_addr_d;
            w_addr_q    <= w_addr_d;
            out_addr_q  <= out_addr_d;
`ifdef MLP_BIAS_EN
            bias_load_q <= bias_load_d;
            bias_addr_q <= bias_addr_d;
`endif
        end
    end

    assign bus.mac_clr      = mac_clr_q;
    assign bus.mac_en       = mac_en_q;
    assign bus.write_neuron = write_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.in_addr      = in_addr_q;
    assign bus.w_addr       = w_addr_q;
    assign bus.out_addr     = out_addr_q;
`ifdef MLP_BIAS_EN
    assign bus.bias_load    = bias_load_q;
    assign bus.bias_addr    = bias_addr_q;
`endif

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Scoreboard bench for mlp_layer_sequencer: expected strobe/address events are queued per layer
// and checked in order against the DUT; covers MLP_BIAS_EN when that macro is defined.
module tb_mlp_layer_sequencer;
    localparam int NAW = 12;
    localparam int WAW = 16;
    localparam int LAT = 2;
`ifdef MLP_BIAS_EN
    localparam int BIAS_C = 1;
`else
    localparam int BIAS_C = 0;
`endif
    localparam int K_CLR  = 1;
    localparam int K_BIAS = 2;
    localparam int K_ACC  = 3;
    localparam int K_WR   = 4;
    localparam int K_DONE = 5;

    typedef struct {
        int          kind;
        logic [15:0] a;
        logic [15:0] b;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mlp_layer_sequencer_if #(.NEURON_AW(NAW), .WEIGHT_AW(WAW)) bus ();

    mlp_layer_sequencer #(.NEURON_AW(NAW), .WEIGHT_AW(WAW), .MAC_LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    ev_t         exp_q[$];
    ev_t         mon_ev;
    int          vectors = 0;
    int          miscompares = 0;
    int          en_cnt = 0, clr_cnt = 0, wr_cnt = 0;
    int          n_strb, obs_kind;
    logic [15:0] obs_a, obs_b;
    bit          mon_en = 1'b0;
`ifdef MLP_BIAS_EN
    logic [11:0] bias_base_v = 12'h000;
`endif

    // Scoreboard monitor: every strobe must match the next expected event.
    always @(negedge clk) begin
        if (mon_en) begin
            n_strb   = int'(bus.mac_clr) + int'(bus.mac_en) + int'(bus.write_neuron) + int'(bus.done);
            obs_kind = 0;
            obs_a    = 16'h0000;
            obs_b    = 16'h0000;
            if (bus.mac_clr === 1'b1) begin obs_kind = K_CLR; clr_cnt++; end
            if (bus.mac_en === 1'b1) begin
                obs_kind = K_ACC; obs_a = {4'h0, bus.in_addr}; obs_b = bus.w_addr; en_cnt++;
            end
            if (bus.write_neuron === 1'b1) begin obs_kind = K_WR; obs_a = {4'h0, bus.out_addr}; wr_cnt++; end
            if (bus.done === 1'b1) obs_kind = K_DONE;
`ifdef MLP_BIAS_EN
            n_strb = n_strb + int'(bus.bias_load);
            if (bus.bias_load === 1'b1) begin obs_kind = K_BIAS; obs_a = {4'h0, bus.bias_addr}; end
`endif
            if (n_strb > 1) begin
                vectors++;
                miscompares++;
                $display("FAIL strobe_overlap: %0d strobes high, required at most 1", n_strb);
            end
            if (obs_kind != 0) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_event: kind %0d a=%h b=%h, required no event", obs_kind, obs_a, obs_b);
                end else begin
                    mon_ev = exp_q.pop_front();
                    if (mon_ev.kind !== obs_kind || mon_ev.a !== obs_a || mon_ev.b !== obs_b) begin
                        miscompares++;
                        $display("FAIL event_order: got kind %0d a=%h b=%h, required kind %0d a=%h b=%h",
                                 obs_kind, obs_a, obs_b, mon_ev.kind, mon_ev.a, mon_ev.b);
                    end
                end
            end
        end
    end

    task automatic push_model(input logic [11:0] ni, input logic [11:0] no, input logic [11:0] ib,
                              input logic [11:0] ob, input logic [15:0] wb);
        logic [15:0] wp;
        logic [11:0] t;
        wp = wb;
        if (ni != 12'h000 && no != 12'h000) begin
            for (int j = 0; j < int'(no); j++) begin
                exp_q.push_back('{K_CLR, 16'h0000, 16'h0000});
`ifdef MLP_BIAS_EN
                t = bias_base_v + 12'(j);
                exp_q.push_back('{K_BIAS, {4'h0, t}, 16'h0000});
`endif
                for (int i = 0; i < int'(ni); i++) begin
                    t = ib + 12'(i);
                    exp_q.push_back('{K_ACC, {4'h0, t}, wp});
                    wp = wp + 16'h0001;
                end
                t = ob + 12'(j);
                exp_q.push_back('{K_WR, {4'h0, t}, 16'h0000});
            end
        end
        exp_q.push_back('{K_DONE, 16'h0000, 16'h0000});
    endtask

    task automatic drive_cfg(input logic [11:0] ni, input logic [11:0] no, input logic [11:0] ib,
                             input logic [11:0] ob, input logic [15:0] wb);
        bus.n_in = ni; bus.n_out = no; bus.in_base = ib; bus.out_base = ob; bus.w_base = wb;
`ifdef MLP_BIAS_EN
        bus.b_base = bias_base_v;
`endif
    endtask

    // One complete layer with optional stall window and stray start pulses while busy.
    task automatic run_layer(input string name, input logic [11:0] ni, input logic [11:0] no,
                             input logic [11:0] ib, input logic [11:0] ob, input logic [15:0] wb,
                             input int stall_at, input int stall_len, input logic [11:0] st_in,
                             input logic [15:0] st_w, input int glitch_at);
        int n, exp_lat;
        bit seen;
        exp_lat = (ni == 12'h000 || no == 12'h000) ? 1 : 1 + int'(no) * (int'(ni) + LAT + 2 + BIAS_C) + stall_len;
        push_model(ni, no, ib, ob, wb);
        en_cnt = 0; clr_cnt = 0; wr_cnt = 0;
        @(negedge clk);
        drive_cfg(ni, no, ib, ob, wb);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 1;
        seen = 1'b0;
        while (!seen && n <= 500) begin
            if (stall_len > 0 && n > stall_at && n <= stall_at + stall_len) begin
                vectors++;
                if (bus.mac_en !== 1'b0 || bus.mac_clr !== 1'b0 || bus.write_neuron !== 1'b0 ||
                    bus.in_addr !== st_in || bus.w_addr !== st_w) begin
                    miscompares++;
                    $display("FAIL %s_stall_hold: cyc %0d en=%b in=%h w=%h, required en=0 in=%h w=%h",
                             name, n, bus.mac_en, bus.in_addr, bus.w_addr, st_in, st_w);
                end
            end
            if (stall_len > 0 && n == stall_at) bus.stall = 1'b1;
            if (stall_len > 0 && n == stall_at + stall_len) bus.stall = 1'b0;
            if (glitch_at > 0 && n == glitch_at) bus.start = 1'b1;
            if (glitch_at > 0 && n == glitch_at + 2) bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                vectors++;
                if (bus.busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL %s_busy_at_done: busy=%b, required 1", name, bus.busy);
                end
            end else begin
                @(negedge clk);
                n++;
            end
        end
        bus.stall = 1'b0;
        bus.start = 1'b0;
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL %s_timeout: no done within %0d cycles, required done at %0d", name, n, exp_lat);
        end else if (n !== exp_lat) begin
            miscompares++;
            $display("FAIL %s_latency: done at cycle %0d, required %0d", name, n, exp_lat);
        end
        @(negedge clk);
        vectors++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_after_done: busy=%b done=%b, required 0 0", name, bus.busy, bus.done);
        end
        vectors++;
        if (en_cnt !== int'(ni) * int'(no) || clr_cnt !== ((ni == 12'h000) ? 0 : int'(no)) ||
            wr_cnt !== ((ni == 12'h000) ? 0 : int'(no))) begin
            miscompares++;
            $display("FAIL %s_counts: en=%0d clr=%0d wr=%0d, required en=%0d clr/wr=%0d", name,
                     en_cnt, clr_cnt, wr_cnt, int'(ni) * int'(no), (ni == 12'h000) ? 0 : int'(no));
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_missing_events: %0d left, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_idle_outputs(input string name);
        vectors++;
        if (bus.mac_clr !== 1'b0 || bus.mac_en !== 1'b0 || bus.write_neuron !== 1'b0 ||
            bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_strobes: clr=%b en=%b wr=%b busy=%b done=%b, required all 0", name,
                     bus.mac_clr, bus.mac_en, bus.write_neuron, bus.busy, bus.done);
        end
        vectors++;
        if (bus.in_addr !== 12'h000 || bus.w_addr !== 16'h0000 || bus.out_addr !== 12'h000) begin
            miscompares++;
            $display("FAIL %s_addrs: in=%h w=%h out=%h, required 000 0000 000", name,
                     bus.in_addr, bus.w_addr, bus.out_addr);
        end
`ifdef MLP_BIAS_EN
        vectors++;
        if (bus.bias_load !== 1'b0 || bus.bias_addr !== 12'h000) begin
            miscompares++;
            $display("FAIL %s_bias: load=%b addr=%h, required 0 000", name, bus.bias_load, bus.bias_addr);
        end
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_basic();
        run_layer("basic", 12'd3, 12'd2, 12'h010, 12'h100, 16'h0000, 0, 0, 12'h000, 16'h0000, 0);
    endtask

    task automatic test_zero_count();
        run_layer("zero_in", 12'd0, 12'd5, 12'h010, 12'h100, 16'h0000, 0, 0, 12'h000, 16'h0000, 0);
        run_layer("zero_out", 12'd3, 12'd0, 12'h010, 12'h100, 16'h0000, 0, 0, 12'h000, 16'h0000, 0);
    endtask

    task automatic test_stall();
        run_layer("stall", 12'd3, 12'd2, 12'h010, 12'h100, 16'h0000, 3, 3, 12'h011, 16'h0001, 0);
    endtask

    task automatic test_reset_mid_layer();
        int n;
        mon_en = 1'b0;
        @(negedge clk);
        drive_cfg(12'd3, 12'd2, 12'h010, 12'h100, 16'h0000);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (n = 1; n < 9; n++) @(negedge clk);
        vectors++;
        if (bus.mac_en !== 1'b1 || bus.in_addr !== 12'h010 || bus.w_addr !== 16'h0003) begin
            miscompares++;
            $display("FAIL midrst_pre: en=%b in=%h w=%h, required 1 010 0003", bus.mac_en, bus.in_addr, bus.w_addr);
        end
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("midrst");
        rst = 1'b0;
        exp_q.delete();
        mon_en = 1'b1;
        run_layer("after_rst", 12'd3, 12'd2, 12'h010, 12'h100, 16'h0000, 0, 0, 12'h000, 16'h0000, 0);
    endtask

    task automatic test_wrap();
        run_layer("wrap_w", 12'd4, 12'd1, 12'h010, 12'h100, 16'hFFFE, 0, 0, 12'h000, 16'h0000, 3);
        run_layer("wrap_n", 12'd4, 12'd2, 12'hFFE, 12'hFFF, 16'h1234, 0, 0, 12'h000, 16'h0000, 0);
    endtask

`ifdef MLP_BIAS_EN
    task automatic test_bias();
        bias_base_v = 12'h200;
        run_layer("bias", 12'd3, 12'd2, 12'h010, 12'h100, 16'h0000, 0, 0, 12'h000, 16'h0000, 0);
    endtask
`endif

    initial begin
        bus.start = 1'b0; bus.stall = 1'b0;
        bus.n_in = 12'h000; bus.n_out = 12'h000; bus.in_base = 12'h000; bus.out_base = 12'h000;
        bus.w_base = 16'h0000;
`ifdef MLP_BIAS_EN
        bus.b_base = 12'h000;
`endif
        test_reset();
        test_basic();
        test_zero_count();
        test_stall();
        test_reset_mid_layer();
        test_wrap();
`ifdef MLP_BIAS_EN
        test_bias();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
